// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory request/response plus the decode-side handshake.
// The slave modport is the fetch_queue view; the master modport is the memory/decode environment.
interface fetch_queue_if #(
  parameter int ADDRESS_BITS = 16
);
  logic                    next_PC_select;
  logic [ADDRESS_BITS-1:0] target_PC;
  logic                    imem_req;
  logic [ADDRESS_BITS-1:0] imem_addr;
  logic                    imem_ready;
  logic                    imem_rvalid;
  logic [31:0]             imem_rdata;
  logic                    out_valid;
  logic                    out_ready;
  logic [ADDRESS_BITS-1:0] PC;
  logic [31:0]             instruction;

  modport slave (
    input  next_PC_select, target_PC, imem_ready, imem_rvalid, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, PC, instruction
  );

  modport master (
    output next_PC_select, target_PC, imem_ready, imem_rvalid, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, PC, instruction
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order instruction fetch with a tagged request FIFO and a small output queue toward decode.
// Define FETCH_BYPASS_EN to present a response straight to decode when the queue is empty.
module fetch_queue #(
  parameter int                      ADDRESS_BITS = 16,
  parameter int                      DEPTH        = 4,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
  input logic          clock,
  input logic          reset,
  fetch_queue_if.slave bus
);
  localparam int                PW      = $clog2(DEPTH);
  localparam int                CW      = PW + 1;
  localparam logic [CW:0]       DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [31:0]       NOP     = 32'h0000_0013;

  logic [ADDRESS_BITS-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]           count_q, count_d;
  logic [CW-1:0]           inflight_q, inflight_d;
  logic [CW-1:0]           drop_q, drop_d;
  logic [PW-1:0]           head_q, head_d, tail_q, tail_d;
  logic [PW-1:0]           tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [ADDRESS_BITS-1:0] tag_mem_q [DEPTH];
  logic [ADDRESS_BITS-1:0] tag_mem_d [DEPTH];
  logic [ADDRESS_BITS-1:0] pc_mem_q  [DEPTH];
  logic [ADDRESS_BITS-1:0] pc_mem_d  [DEPTH];
  logic [31:0]             ins_mem_q [DEPTH];
  logic [31:0]             ins_mem_d [DEPTH];

  logic [CW:0]             occupancy;
  logic                    issue, accept, resp_valid, resp_drop, resp_keep;
  logic                    head_valid, bypass, pop, push, redirect;
  logic [ADDRESS_BITS-1:0] resp_pc;

  always_comb begin
    occupancy  = {1'b0, count_q} + {1'b0, inflight_q};
    // A response with nothing outstanding is stale (e.g. issued before reset) and is ignored.
    resp_valid = bus.imem_rvalid && (inflight_q != '0);
    resp_drop  = resp_valid && (drop_q != '0);
    resp_keep  = resp_valid && (drop_q == '0);
    resp_pc    = tag_mem_q[tag_rd_q];
    head_valid = (count_q != '0);
`ifdef FETCH_BYPASS_EN
    bypass     = resp_keep && !head_valid;
`else
    bypass     = 1'b0;
`endif
    bus.out_valid   = head_valid || bypass;
    bus.PC          = head_valid ? pc_mem_q[head_q]  : (bypass ? resp_pc        : '0);
    bus.instruction = head_valid ? ins_mem_q[head_q] : (bypass ? bus.imem_rdata : NOP);

    redirect = bus.out_valid && bus.out_ready && bus.next_PC_select;
    pop      = head_valid && bus.out_ready;
    push     = resp_keep && !(bypass && bus.out_ready) && !redirect;
    // Issue looks only at registered occupancy so a pop never races a new request.
    issue    = reset && (occupancy < DEPTH_C) && !redirect;
    accept   = issue && bus.imem_ready;

    bus.imem_req  = issue;
    bus.imem_addr = fetch_pc_q;

    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    tag_mem_d  = tag_mem_q;
    pc_mem_d   = pc_mem_q;
    ins_mem_d  = ins_mem_q;

    if (accept) begin
      tag_mem_d[tag_wr_q] = fetch_pc_q;
      tag_wr_d            = tag_wr_q + PW'(1);
      fetch_pc_d          = fetch_pc_q + ADDRESS_BITS'(4);
    end
    if (resp_valid) begin
      tag_rd_d = tag_rd_q + PW'(1);
    end
    if (push) begin
      pc_mem_d[tail_q]  = resp_pc;
      ins_mem_d[tail_q] = bus.imem_rdata;
      tail_d            = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end

    inflight_d = inflight_q + CW'(accept) - CW'(resp_valid);
    count_d    = count_q + CW'(push) - CW'(pop);
    drop_d     = drop_q - CW'(resp_drop);

    // Everything still outstanding after this edge belongs to the abandoned stream.
    if (redirect) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      drop_d     = inflight_d;
      fetch_pc_d = bus.target_PC & ~ADDRESS_BITS'(3);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_mem_q[i] <= '0;
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= NOP;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      for (int i = 0; i < DEPTH; i++) begin
        tag_mem_q[i] <= tag_mem_d[i];
        pc_mem_q[i]  <= pc_mem_d[i];
        ins_mem_q[i] <= ins_mem_d[i];
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a memory model answers accepted requests in order,
// the stimulus queues expected {PC, instruction} pairs and a monitor checks every consumed head.
`timescale 1ns/1ps
module tb_fetch_queue;
  localparam int          AB  = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
  localparam int          FIRST_LAT = 1;
`else
  localparam int          FIRST_LAT = 2;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fetch_queue_if #(.ADDRESS_BITS(AB)) bus ();

  fetch_queue #(.ADDRESS_BITS(AB), .DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [AB-1:0] addr;
    int            due;
  } mreq_t;

  int            compared   = 0;
  int            mismatched = 0;
  int            cyc        = 0;
  int            lat        = 1;
  int            resp_limit = 1000000;
  int            delivered  = 0;
  int            first_req_cyc   = -1;
  int            first_valid_cyc = -1;
  bit            ready_en   = 1'b0;
  logic [7:0]    ready_pat  = 8'hFF;
  mreq_t         mem_q[$];
  logic [AB-1:0] exp_q[$];
  logic [AB-1:0] req_log[$];
  logic [AB-1:0] redir_pc[$];
  logic [AB-1:0] redir_tgt[$];
  logic [AB-1:0] mon_e;

  // Memory contents: one hand-placed jump at 0x0114, otherwise a tagged pattern.
  function automatic logic [31:0] mem_word(logic [AB-1:0] a);
    return (a == 16'h0114) ? 32'h0140006f : {16'hC0DE, a};
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  task automatic push_seq(logic [AB-1:0] start, int n);
    logic [AB-1:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(a);
      a = a + 16'd4;
    end
  endtask

  task automatic run(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drain(string name, int budget);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      @(negedge clock);
      k++;
    end
    #3;
    check(name, 64'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #3;
    reset = 1'b0;
    mem_q.delete();
    exp_q.delete();
    req_log.delete();
    redir_pc.delete();
    redir_tgt.delete();
    first_req_cyc   = -1;
    first_valid_cyc = -1;
    delivered       = 0;
    resp_limit      = 1000000;
    ready_en        = 1'b0;
    ready_pat       = 8'hFF;
    @(negedge clock);
    reset = 1'b1;
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Environment driver: memory responses at the falling edge, decode controls 1ns later.
  always @(negedge clock) begin
    bus.imem_ready = 1'b1;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc && delivered < resp_limit) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
      delivered++;
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    bus.out_ready      = ready_en && ready_pat[cyc % 8] && (exp_q.size() > 0);
    bus.next_PC_select = (redir_pc.size() > 0) && bus.out_valid && (bus.PC == redir_pc[0]);
    bus.target_PC      = (redir_tgt.size() > 0) ? redir_tgt[0] : 16'h0000;
  end

  // Request capture: every accepted request is logged and scheduled for a response.
  always @(negedge clock) begin
    #2;
    if (reset && bus.imem_req && bus.imem_ready) begin
      mem_q.push_back('{addr: bus.imem_addr, due: cyc + lat});
      req_log.push_back(bus.imem_addr);
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
  end

  // Monitor: compares each consumed head against the scoreboard.
  always @(negedge clock) begin
    #2;
    if (reset) begin
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL pop_unexpected: got PC %0h expected none", bus.PC);
        end else begin
          mon_e = exp_q.pop_front();
          check("pop_pc", 64'(bus.PC), 64'(mon_e));
          check("pop_instr", 64'(bus.instruction), 64'(mem_word(mon_e)));
        end
        if (bus.next_PC_select) begin
          check("req_held_on_redirect", 64'(bus.imem_req), 0);
          if (redir_pc.size() > 0) begin
            void'(redir_pc.pop_front());
            void'(redir_tgt.pop_front());
          end
        end
      end else if (!bus.out_valid) begin
        check("idle_nop", 64'(bus.instruction), 64'(NOP));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    // Reset values.
    #12;
    check("rst_out_valid", 64'(bus.out_valid), 0);
    check("rst_imem_req", 64'(bus.imem_req), 0);
    check("rst_pc", 64'(bus.PC), 0);
    check("rst_instr", 64'(bus.instruction), 64'(NOP));
    @(negedge clock);
    reset = 1'b1;

    // Stream with 1-cycle memory and decode always ready.
    lat = 1;
    push_seq(16'h0000, 10);
    ready_en = 1'b1;
    drain("A_drain", 60);
    check("A_addr0", 64'(req_log[0]), 64'h0000);
    check("A_addr1", 64'(req_log[1]), 64'h0004);
    check("A_addr2", 64'(req_log[2]), 64'h0008);
    check("A_first_latency", 64'(first_valid_cyc - first_req_cyc), 64'(FIRST_LAT));

    // Decode stalled: exactly DEPTH requests, then issue stops.
    do_reset();
    run(10);
    #2;
    check("B_req_count", 64'(req_log.size()), 4);
    for (int i = 0; i < 4; i++) check("B_req_addr", 64'(req_log[i]), 64'(4 * i));
    check("B_imem_req_full", 64'(bus.imem_req), 0);
    check("B_head_valid", 64'(bus.out_valid), 1);
    check("B_head_pc", 64'(bus.PC), 0);
    push_seq(16'h0000, 6);
    ready_en = 1'b1;
    drain("B_drain", 60);

    // Redirect chain with 2-cycle memory and a stuttering decode.
    do_reset();
    lat = 2;
    ready_pat = 8'b1101_1011;
    redir_pc.push_back(16'h0000); redir_tgt.push_back(16'h0100);
    redir_pc.push_back(16'h0114); redir_tgt.push_back(16'h0128);
    redir_pc.push_back(16'h0130); redir_tgt.push_back(16'h0156);
    redir_pc.push_back(16'h0158); redir_tgt.push_back(16'hFFF8);
    push_seq(16'h0000, 1);
    push_seq(16'h0100, 6);
    push_seq(16'h0128, 3);
    push_seq(16'h0154, 2);
    push_seq(16'hFFF8, 4);
    ready_en = 1'b1;
    drain("C_drain", 200);
    check("C_redirects_taken", 64'(redir_pc.size()), 0);

    // Reset while 3 entries are queued and 1 response is still outstanding.
    do_reset();
    lat = 1;
    resp_limit = 3;
    k = 0;
    while (!(req_log.size() == 4 && delivered == 3) && k < 30) begin
      @(negedge clock);
      k++;
    end
    check("D_fill_reached", 64'(k < 30), 1);
    run(2);
    #2;
    check("D_no_extra_req", 64'(req_log.size()), 4);
    check("D_valid_before", 64'(bus.out_valid), 1);
    #1;
    reset = 1'b0;
    resp_limit = 1000000;
    exp_q.delete();
    req_log.delete();
    first_req_cyc = -1;
    #1;
    check("D_rst_out_valid", 64'(bus.out_valid), 0);
    check("D_rst_instr", 64'(bus.instruction), 64'(NOP));
    check("D_rst_imem_req", 64'(bus.imem_req), 0);
    check("D_rst_pc", 64'(bus.PC), 0);
    @(negedge clock);
    reset = 1'b1;
    push_seq(16'h0000, 6);
    ready_en = 1'b1;
    drain("D_drain", 60);
    check("D_restart_addr", 64'(req_log[0]), 64'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
